// File: rtl/ff_cmd_pkg.sv
// ff_cmd_pkg: op encodings and FSM state type shared by the command arbiter.
package ff_cmd_pkg;
    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;
    typedef enum logic [1:0] {IDLE, GRANT, DRIVE, DONE} state_e;
endpackage

// File: rtl/ff_cmd_arbiter_sr_cell.sv
// sr_cell: one clocked SR storage bit, q_next = S | (~R & q).
module sr_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_n
);
    logic q_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= 1'b0;
        else     q_q <= s | (~r & q_q);
    assign q   = q_q;
    assign q_n = ~q_q;
endmodule

// File: rtl/ff_cmd_arbiter.sv
// ff_cmd_arbiter: round-robin arbiter serializing SET/RESET/TOGGLE/LOAD
// commands onto a bank of SR storage bits, one command per three cycles.
module ff_cmd_arbiter
    import ff_cmd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IW   = $clog2(NFF),
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IW*NREQ-1:0]   req_idx,
    input  logic [NREQ-1:0]      req_d,
    output logic [NFF-1:0]       s_drv,
    output logic [NFF-1:0]       r_drv,
    output logic [NFF-1:0]       q,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_q,
    output logic                 busy
);
    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, id_q, gnt_id;
    logic [IW-1:0]   idx_q, sel_idx;
    logic [NFF-1:0]  s_drv_q, r_drv_q, q_n;
    logic [1:0]      sel_op;
    logic            gnt_found, sel_d, sel_s, sel_r, take;

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
        sel_op  = req_op[2*int'(gnt_id) +: 2];
        sel_idx = req_idx[IW*int'(gnt_id) +: IW];
        sel_d   = req_d[gnt_id];
        // S and R are complementary per op, so they can never collide
        sel_s   = (sel_op == OP_SET) | ((sel_op == OP_TOGGLE) & q_n[sel_idx]) | ((sel_op == OP_LOAD) & sel_d);
        sel_r   = (sel_op == OP_RESET) | ((sel_op == OP_TOGGLE) & q[sel_idx]) | ((sel_op == OP_LOAD) & ~sel_d);
        take    = (state_q == GRANT) & gnt_found;
        req_ready = take ? NREQ'(1) << gnt_id : '0;
        state_d = (state_q == IDLE || state_q == DONE) ? (|req_valid ? GRANT : IDLE) :
                  (state_q == GRANT) ? (gnt_found ? DRIVE : IDLE) : DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            s_drv_q <= '0;
            r_drv_q <= '0;
        end else begin
            state_q <= state_d;
            s_drv_q <= take ? NFF'(sel_s) << sel_idx : '0;
            r_drv_q <= take ? NFF'(sel_r) << sel_idx : '0;
            if (take) begin
                id_q  <= gnt_id;
                idx_q <= sel_idx;
                ptr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NFF; i++) begin : g_cell
        sr_cell u_cell (
            .clk (clk),
            .rst (rst),
            .s   (s_drv_q[i]),
            .r   (r_drv_q[i]),
            .q   (q[i]),
            .q_n (q_n[i])
        );
    end

    assign s_drv     = s_drv_q;
    assign r_drv     = r_drv_q;
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_q     = (state_q == DONE) & q[idx_q];
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ff_cmd_arbiter.sv
// tb_ff_cmd_arbiter: directed and random commands checked against a
// command-level reference model of the arbiter and storage bits.
module tb_ff_cmd_arbiter;
    import ff_cmd_pkg::*;
    localparam int N  = 4;
    localparam int F  = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op = '0;
    logic [IW*N-1:0] req_idx = '0;
    logic [N-1:0]    req_d = '0;
    logic [F-1:0]    s_drv, r_drv, q;
    logic            rsp_valid, rsp_q, busy;
    logic [1:0]      rsp_id;

    ff_cmd_arbiter #(.NREQ(N), .NFF(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_d     (req_d),
        .s_drv     (s_drv),
        .r_drv     (r_drv),
        .q         (q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0, cyc = 0;
    // model: phase 0 idle, 1 arbitrate, 2 drive, 3 respond
    int ph = 0, ptr = 0, cur_id = 0, cur_idx = 0;
    bit cur_v = 0;
    logic [F-1:0] mq = '0;
    bit       pv[N];
    logic [1:0] p_op[N];
    int       p_idx[N];
    bit       p_d[N];
    int g_id[$], g_cyc[$], r_id[$], r_cyc[$];
    bit r_qv[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit result(logic [1:0] op, bit cur, bit d);
        return op == OP_SET ? 1'b1 : op == OP_RESET ? 1'b0 : op == OP_TOGGLE ? !cur : d;
    endfunction

    task automatic arm(int i, logic [1:0] op, int idx, bit d);
        pv[i] = 1; p_op[i] = op; p_idx[i] = idx; p_d[i] = d;
    endtask

    task automatic step();
        int gid;
        bit any;
        logic [F-1:0] es, er;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pv[i];
            req_op[2*i +: 2]    = p_op[i];
            req_idx[IW*i +: IW] = IW'(p_idx[i]);
            req_d[i]            = p_d[i];
        end
        #1;
        cyc++;
        any = 0;
        for (int i = 0; i < N; i++) any |= pv[i];
        gid = -1;
        if (ph == 1)
            for (int k = 0; k < N; k++)
                if (gid < 0 && pv[(ptr + k) % N]) gid = (ptr + k) % N;
        es = '0; er = '0;
        if (ph == 2) begin es[cur_idx] = cur_v; er[cur_idx] = !cur_v; end
        chk("ready", req_ready, gid >= 0 ? 32'(1) << gid : 32'(0));
        chk("s_drv", s_drv, es);
        chk("r_drv", r_drv, er);
        chk("sr_excl", s_drv & r_drv, 0);
        chk("busy", busy, ph != 0);
        chk("rsp_valid", rsp_valid, ph == 3);
        if (ph == 3) begin
            chk("rsp_id", rsp_id, cur_id);
            chk("rsp_q", rsp_q, cur_v);
        end
        chk("q", q, mq);
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
        if (rsp_valid) begin r_id.push_back(rsp_id); r_qv.push_back(rsp_q); r_cyc.push_back(cyc); end
        case (ph)
            1: if (gid >= 0) begin
                cur_id = gid; cur_idx = p_idx[gid];
                cur_v = result(p_op[gid], mq[cur_idx], p_d[gid]);
                ptr = (gid + 1) % N; pv[gid] = 0; ph = 2;
            end else ph = 0;
            2: begin mq[cur_idx] = cur_v; ph = 3; end
            default: ph = any ? 1 : 0;
        endcase
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1; req_valid = '0;
        for (int i = 0; i < N; i++) pv[i] = 0;
        ph = 0; ptr = 0; mq = '0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_sr", s_drv | r_drv, 0);
        chk("rst_q", q, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_q}, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int b, n;
        for (int i = 0; i < N; i++) begin pv[i] = 0; p_op[i] = 0; p_idx[i] = 0; p_d[i] = 0; end
        do_rst();
        // single SET idx 3 from requester 0
        arm(0, OP_SET, 3, 0);
        b = r_id.size(); n = g_id.size();
        repeat (6) step();
        chk("set_q", q, 8'h08);
        chk("set_nrsp", r_id.size() - b, 1);
        if (r_id.size() > b && g_id.size() > n) begin
            chk("set_rsp_q", r_qv[b], 1);
            chk("set_latency", r_cyc[b] - g_cyc[n], 2);
        end
        // toggle sequence on bit 5
        b = r_qv.size();
        arm(0, OP_SET, 5, 0);    repeat (5) step();
        arm(0, OP_TOGGLE, 5, 0); repeat (5) step();
        arm(0, OP_TOGGLE, 5, 0); repeat (5) step();
        arm(0, OP_LOAD, 5, 0);   repeat (5) step();
        chk("tog_nrsp", r_qv.size() - b, 4);
        if (r_qv.size() >= b + 4) begin
            chk("tog_seq", {r_qv[b], r_qv[b+1], r_qv[b+2], r_qv[b+3]}, 4'b1010);
        end
        chk("load_q5", q[5], 0);
        // round-robin under continuous requests
        do_rst();
        for (int i = 0; i < N; i++) arm(i, OP_SET, i, 0);
        n = g_id.size();
        repeat (16) begin
            step();
            for (int i = 0; i < N; i++) if (!pv[i]) arm(i, OP_SET, i, 0);
        end
        chk("rr_ngrants", g_id.size() - n >= 5, 1);
        if (g_id.size() >= n + 5)
            for (int k = 0; k < 5; k++) begin
                chk("rr_id", g_id[n+k], k % N);
                if (k > 0) chk("rr_spacing", g_cyc[n+k] - g_cyc[n+k-1], 3);
            end
        // same-bit serialization
        do_rst();
        arm(1, OP_TOGGLE, 0, 0); arm(2, OP_TOGGLE, 0, 0);
        b = r_id.size();
        repeat (10) step();
        chk("ser_nrsp", r_id.size() - b, 2);
        if (r_id.size() >= b + 2)
            chk("ser_seq", {r_id[b], 1'(r_qv[b]), r_id[b+1], 1'(r_qv[b+1])}, {32'(1), 1'b1, 32'(2), 1'b0});
        // reset during DRIVE aborts the command
        do_rst();
        arm(2, OP_SET, 1, 0);
        for (int k = 0; k < 10 && ph != 2; k++) step();
        n = r_id.size();
        do_rst();
        repeat (3) step();
        chk("abort_norsp", r_id.size(), n);
        chk("abort_q", q, 0);
        arm(3, OP_SET, 2, 0); arm(1, OP_SET, 4, 0);
        b = g_id.size();
        repeat (5) step();
        chk("abort_regrant", g_id.size() > b ? g_id[b] : 99, 1);
        // random traffic
        do_rst();
        repeat (10000) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(0, 3) == 0)
                    arm(i, 2'($urandom_range(0, 3)), $urandom_range(0, F - 1), 1'($urandom_range(0, 1)));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
